fp_to_int_seq: RTL and testbench



---
 rtl/fp_to_int_seq_if.sv | 21 ++
 rtl/fp_to_int_seq.sv | 165 ++++++++++++++++
 tb/tb_fp_to_int_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_to_int_seq_if.sv
// Handshake bundle for the float-to-integer converter.
// The requester uses master; the converter uses slave.
interface fp_to_int_seq_if;
    logic        start;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        invalid;
    logic        inexact;

    modport master (
        output start, a,
        input  busy, done, result, invalid, inexact
    );

    modport slave (
        input  start, a,
        output busy, done, result, invalid, inexact
    );
endinterface

// File: rtl/fp_to_int_seq.sv
// Multi-cycle IEEE-754 single to signed 32-bit integer converter, round toward zero.
// The magnitude is aligned by a 1-bit-per-cycle shifter, so latency follows the exponent.
module fp_to_int_seq #(
    parameter logic [31:0] NAN_RESULT = 32'h7FFF_FFFF
) (
    input logic           clk,
    input logic           rst_n,
    fp_to_int_seq_if.slave bus
);
    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

    state_e      state_q, state_d;
    logic [31:0] mant_q, mant_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        sticky_q, sticky_d;
    logic        sign_q, sign_d;
    logic        inv_q, inv_d;
    logic [31:0] result_q, result_d;
    logic        invalid_q, invalid_d;
    logic        inexact_q, inexact_d;
    logic        done_q, done_d;

    logic        s_in;
    logic [7:0]  e_in;
    logic [22:0] f_in;

    logic        cls_special;
    logic [31:0] cls_result;
    logic        cls_invalid;
    logic        cls_inexact;
    logic        cls_left;
    logic [4:0]  cls_cnt;

    assign s_in = bus.a[31];
    assign e_in = bus.a[30:23];
    assign f_in = bus.a[22:0];

    always_comb begin
        cls_special = 1'b1;
        cls_result  = '0;
        cls_invalid = 1'b0;
        cls_inexact = 1'b0;
        cls_left    = 1'b0;
        cls_cnt     = '0;
        if (e_in == 8'hFF) begin
            cls_invalid = 1'b1;
            if (f_in != '0) begin
                cls_result = NAN_RESULT;
            end else begin
                cls_result = s_in ? INT_MIN : INT_MAX;
            end
        end else if (bus.a == 32'hCF00_0000) begin
            cls_result = INT_MIN;
        end else if (e_in >= 8'd158) begin
            cls_invalid = 1'b1;
            cls_result  = s_in ? INT_MIN : INT_MAX;
        end else if (e_in < 8'd127) begin
            cls_inexact = |bus.a[30:0];
        end else begin
            cls_special = 1'b0;
            // Normal exponents span 127..157, so |e-150| fits in 5 bits and only
            // the low exponent bits matter (150 mod 32 = 22).
            if (e_in >= 8'd150) begin
                cls_left = 1'b1;
                cls_cnt  = e_in[4:0] - 5'd22;
            end else begin
                cls_cnt  = 5'd22 - e_in[4:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mant_q    <= '0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
            sticky_q  <= 1'b0;
            sign_q    <= 1'b0;
            inv_q     <= 1'b0;
            result_q  <= '0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mant_q    <= mant_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            sticky_q  <= sticky_d;
            sign_q    <= sign_d;
            inv_q     <= inv_d;
            result_q  <= result_d;
            invalid_q <= invalid_d;
            inexact_q <= inexact_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mant_d    = mant_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        sticky_d  = sticky_q;
        sign_d    = sign_q;
        inv_d     = inv_q;
        result_d  = result_q;
        invalid_d = invalid_q;
        inexact_d = inexact_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    inv_d    = cls_invalid;
                    left_d   = cls_left;
                    cnt_d    = cls_cnt;
                    // Specials park their final value in the mantissa with a positive
                    // sign and their inexact flag in sticky, sharing the FINISH path.
                    if (cls_special) begin
                        mant_d   = cls_result;
                        sign_d   = 1'b0;
                        sticky_d = cls_inexact;
                        state_d  = StFinish;
                    end else begin
                        mant_d   = {8'd0, 1'b1, f_in};
                        sign_d   = s_in;
                        sticky_d = 1'b0;
                        state_d  = (cls_cnt == '0) ? StFinish : StShift;
                    end
                end
            end
            StShift: begin
                if (left_q) begin
                    mant_d = mant_q << 1;
                end else begin
                    mant_d   = mant_q >> 1;
                    sticky_d = sticky_q | mant_q[0];
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                result_d  = sign_q ? (~mant_q + 32'd1) : mant_q;
                invalid_d = inv_q;
                inexact_d = left_q ? 1'b0 : sticky_q;
                done_d    = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.invalid = invalid_q;
    assign bus.inexact = inexact_q;
endmodule

// File: tb/tb_fp_to_int_seq.sv
// Scoreboard bench for fp_to_int_seq: stimulus pushes model predictions, a monitor
// checks every done pulse (value, flags, timing) and that outputs hold in between.
module tb_fp_to_int_seq;
    localparam logic [31:0] NAN_RESULT = 32'h7FFF_FFFF;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;

    fp_to_int_seq_if bus ();

    fp_to_int_seq #(.NAN_RESULT(NAN_RESULT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] result;
        logic        invalid;
        logic        inexact;
        int unsigned due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: value = 1.f * 2^(e-127), truncated toward zero, with range rules.
    function automatic exp_t model(input logic [31:0] a);
        exp_t        r;
        int          k;
        logic [63:0] m;
        logic [63:0] mag;
        r.a       = a;
        r.result  = '0;
        r.invalid = 1'b0;
        r.inexact = 1'b0;
        r.due     = 1;
        if (a[30:23] == 8'hFF) begin
            r.invalid = 1'b1;
            if (a[22:0] != 0) r.result = NAN_RESULT;
            else r.result = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (a == 32'hCF00_0000) begin
            r.result = 32'h8000_0000;
        end else if (a[30:23] >= 8'd158) begin
            r.invalid = 1'b1;
            r.result  = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (a[30:23] < 8'd127) begin
            r.inexact = (a[30:0] != 0);
        end else begin
            k = int'(a[30:23]) - 127;
            m = {40'd0, 1'b1, a[22:0]};
            if (k >= 23) begin
                mag   = m << (k - 23);
                r.due = k - 23 + 1;
            end else begin
                mag       = m >> (23 - k);
                r.inexact = (m % (64'd1 << (23 - k))) != 0;
                r.due     = 23 - k + 1;
            end
            r.result = a[31] ? 32'(-mag) : mag[31:0];
        end
        return r;
    endfunction

    task automatic issue(input logic [31:0] a, input bit now);
        exp_t e;
        if (!now) @(negedge clk);
        bus.a     = a;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        e     = model(a);
        e.due = e.due + cyc;
        sb.push_back(e);
        bus.start = 1'b0;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        check("wait_done", {31'd0, bus.done}, 32'd1);
    endtask

    // Monitor
    exp_t        mon_e;
    logic [31:0] held_r;
    logic [1:0]  held_f;

    always @(negedge clk) begin
        if (!rst_n) begin
            held_r = '0;
            held_f = '0;
        end else if (bus.done) begin
            check("done_busy_low", {31'd0, bus.busy}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", {31'd0, bus.done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result", bus.result, mon_e.result);
                check("invalid", {31'd0, bus.invalid}, {31'd0, mon_e.invalid});
                check("inexact", {31'd0, bus.inexact}, {31'd0, mon_e.inexact});
                check("done_cycle", cyc, mon_e.due);
                if (n_fail != 0 && bus.result !== mon_e.result)
                    $display("  operand %h", mon_e.a);
            end
            held_r = bus.result;
            held_f = {bus.invalid, bus.inexact};
        end else begin
            check("hold_result", bus.result, held_r);
            check("hold_flags", {30'd0, bus.invalid, bus.inexact}, {30'd0, held_f});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] directed [14] = '{
        32'h3F80_0000, 32'hC0B8_0000, 32'h4B00_0000, 32'h4EFF_FFFF,
        32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000,
        32'h3F00_0000, 32'h8000_0000, 32'h0000_0001, 32'h7F80_0000,
        32'hCF00_0001, 32'h3FFF_FFFF
    };

    initial begin
        logic [31:0] ra;
        logic [7:0]  re;
        logic [22:0] rf;
        bit          now;
        bus.start = 1'b0;
        bus.a     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_flags", {30'd0, bus.invalid, bus.inexact}, 32'd0);
        rst_n = 1'b1;

        foreach (directed[i]) begin
            issue(directed[i], 1'b0);
            drain();
        end

        // Start while busy is ignored: only one done, result 1.
        issue(32'h3F80_0000, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.a     = 32'h4000_0000;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        drain();
        repeat (30) @(negedge clk);

        // Start in the done cycle is accepted.
        issue(32'h3F80_0000, 1'b0);
        wait_done();
        issue(32'h4000_0000, 1'b1);
        drain();

        // Asynchronous reset mid-conversion.
        issue(32'h3F80_0000, 1'b0);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_result", bus.result, 32'd0);
        check("arst_flags", {30'd0, bus.invalid, bus.inexact}, 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        issue(32'h3F80_0000, 1'b0);
        drain();

        now = 1'b0;
        repeat (300) begin
            rf = 23'($urandom);
            if ($urandom_range(0, 4) == 0) rf = '0;
            case ($urandom_range(0, 9))
                0:       re = 8'hFF;
                1:       re = 8'($urandom_range(158, 254));
                2:       re = 8'($urandom_range(0, 126));
                3:       re = 8'($urandom_range(150, 157));
                default: re = 8'($urandom_range(127, 157));
            endcase
            ra = {1'($urandom), re, rf};
            if ($urandom_range(0, 19) == 0) ra = 32'hCF00_0000;
            issue(ra, now);
            if ($urandom_range(0, 1) == 1) begin
                wait_done();
                now = 1'b1;
            end else begin
                drain();
                now = 1'b0;
            end
        end
        drain();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
